// File: rtl/handshake_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : handshake_rr_arbiter                                       |
// | Description : Round-robin merge of N_PORTS 4-phase request channels onto |
// |               one 4-phase output channel. Async lreq/rack inputs are     |
// |               synchronised; one transfer in flight at a time.            |
// | Options     : define ARB_STATS_EN to add xfer_cnt and port_hit outputs.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module handshake_rr_arbiter #(
  parameter int N_PORTS     = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         lreq,
  output logic [N_PORTS-1:0]         lack,
  input  logic [N_PORTS*WIDTH-1:0]   ldata,
  output logic                       rreq,
  input  logic                       rack,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(N_PORTS)-1:0] grant_id,
  output logic                       busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]                xfer_cnt,
  output logic [N_PORTS-1:0]         port_hit
`endif
);

  localparam int              PTR_W     = $clog2(N_PORTS);
  localparam logic [PTR_W:0]  C_N_PORTS = (PTR_W+1)'(N_PORTS);
  localparam logic [PTR_W-1:0] C_ONE    = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // (base + off) mod N_PORTS, valid for base, off < N_PORTS
  function automatic logic [PTR_W-1:0] f_wrap_add(input logic [PTR_W-1:0] base,
                                                  input logic [PTR_W-1:0] off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= C_N_PORTS) sum = sum - C_N_PORTS;
    return sum[PTR_W-1:0];
  endfunction

  logic [SYNC_STAGES-1:0][N_PORTS-1:0] r_lreq_sync;
  logic [SYNC_STAGES-1:0]              r_rack_sync;
  logic [N_PORTS-1:0]                  w_lreq_s;
  logic                                w_rack_s;

  state_t             r_state, w_state_next;
  logic               r_rreq, w_rreq_next;
  logic [N_PORTS-1:0] r_lack, w_lack_next;
  logic [WIDTH-1:0]   r_rdata, w_rdata_next;
  logic [PTR_W-1:0]   r_grant, w_grant_next;
  logic [PTR_W-1:0]   r_ptr, w_ptr_next;
  logic               w_found;
  logic [PTR_W-1:0]   w_winner;
  logic [PTR_W-1:0]   w_idx;

  // Multi-flop synchronisers for the asynchronous handshake inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lreq_sync <= '0;
      r_rack_sync <= '0;
    end else begin
      r_lreq_sync <= {r_lreq_sync[SYNC_STAGES-2:0], lreq};
      r_rack_sync <= {r_rack_sync[SYNC_STAGES-2:0], rack};
    end
  end

  assign w_lreq_s = r_lreq_sync[SYNC_STAGES-1];
  assign w_rack_s = r_rack_sync[SYNC_STAGES-1];

  // Rotating priority search: first synced request at ptr, ptr+1, ... (wrapping)
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      w_idx = f_wrap_add(r_ptr, PTR_W'(i));
      if (w_lreq_s[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Next-state and registered-output logic of the handshake FSM
  always_comb begin
    w_state_next = r_state;
    w_rreq_next  = r_rreq;
    w_lack_next  = r_lack;
    w_rdata_next = r_rdata;
    w_grant_next = r_grant;
    w_ptr_next   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_rdata_next = ldata[w_winner*WIDTH +: WIDTH];
          w_grant_next = w_winner;
          w_rreq_next  = 1'b1;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (w_rack_s) begin
          w_rreq_next           = 1'b0;
          w_lack_next           = '0;
          w_lack_next[r_grant]  = 1'b1;
          w_state_next          = S_ACK;
        end
      end
      S_ACK: begin
        // Requiring the granted lreq to fall first prevents a stale request
        // from being granted twice.
        if (!w_rack_s && !w_lreq_s[r_grant]) begin
          w_lack_next  = '0;
          w_ptr_next   = f_wrap_add(r_grant, C_ONE);
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_rreq_next  = 1'b0;
        w_lack_next  = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rreq  <= 1'b0;
      r_lack  <= '0;
      r_rdata <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_rreq  <= w_rreq_next;
      r_lack  <= w_lack_next;
      r_rdata <= w_rdata_next;
      r_grant <= w_grant_next;
      r_ptr   <= w_ptr_next;
    end
  end

  assign lack     = r_lack;
  assign rreq     = r_rreq;
  assign rdata    = r_rdata;
  assign grant_id = r_grant;
  assign busy     = (r_state != S_IDLE);

`ifdef ARB_STATS_EN
  logic [15:0]        r_xfer_cnt;
  logic [N_PORTS-1:0] r_port_hit;
  logic               w_xfer_done;
  logic               w_grant_evt;

  assign w_xfer_done = (r_state == S_ACK)  && (w_state_next == S_IDLE);
  assign w_grant_evt = (r_state == S_IDLE) && (w_state_next == S_SEND);

  // Completed-transfer counter (wraps) and sticky per-port grant flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xfer_cnt <= '0;
      r_port_hit <= '0;
    end else begin
      if (w_xfer_done) r_xfer_cnt <= r_xfer_cnt + 16'd1;
      if (w_grant_evt) r_port_hit[w_winner] <= 1'b1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
  assign port_hit = r_port_hit;
`else
  // Statistics outputs are not present in this build.
`endif

endmodule
`default_nettype wire
